rc4_phase_sequencer: RTL

//  Top-level RC4 controller. Sequences the three S-memory phases (init S[i]=i, KSA key schedule, PRGA decrypt)

---
 rtl/rc4_pkg.sv | 21 ++
 rtl/rc4_ram_mux.sv | 18 +
 rtl/rc4_phase_sequencer.sv | 112 +++++++++++
 3 files changed

// File: rtl/rc4_pkg.sv
// Shared types for the RC4 controller: phase encoding and S-RAM request bundle.
package rc4_pkg;
  localparam int S_ADDR_W = 8;
  localparam int S_DATA_W = 8;
  localparam int S_DEPTH  = 2**S_ADDR_W;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INIT     = 3'd1,
    KSA      = 3'd2,
    PRGA     = 3'd3,
    NEXT_KEY = 3'd4,
    DONE     = 3'd5
  } phase_t;

  typedef struct packed {
    logic [S_ADDR_W-1:0] addr;
    logic [S_DATA_W-1:0] wdata;
    logic                wren;
  } s_ram_req_t;
endpackage

// File: rtl/rc4_ram_mux.sv
// Single-port S-RAM arbiter: passes through the request of the engine owning the current phase.
module rc4_ram_mux
  import rc4_pkg::*;
(
  input  phase_t           phase,
  input  s_ram_req_t [2:0] req,    // [0] init, [1] ksa, [2] prga
  output s_ram_req_t       s_req
);
  always_comb begin
    s_req = '0;
    case (phase)
      INIT:    s_req = req[0];
      KSA:     s_req = req[1];
      PRGA:    s_req = req[2];
      default: s_req = '0;
    endcase
  end
endmodule

// File: rtl/rc4_phase_sequencer.sv
// RC4 top-level phase sequencer: init -> KSA -> PRGA with strobe handshakes and S-RAM arbitration.
// Optional key-search retry loop enabled by defining RC4_KEY_SEARCH_EN.
module rc4_phase_sequencer
  import rc4_pkg::*;
#(
  parameter int ADDR_W = S_ADDR_W,
  parameter int DATA_W = S_DATA_W,
  parameter int KEY_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KEY_W-1:0]  key_in,
  input  logic              init_fin,
  input  logic              ksa_fin,
  input  logic              prga_fin,
  input  logic              prga_ok,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_wdata,
  input  logic              init_wren,
  input  logic [ADDR_W-1:0] ksa_addr,
  input  logic [DATA_W-1:0] ksa_wdata,
  input  logic              ksa_wren,
  input  logic [ADDR_W-1:0] prga_addr,
  input  logic [DATA_W-1:0] prga_wdata,
  input  logic              prga_wren,
  output logic              init_start,
  output logic              ksa_start,
  output logic              prga_start,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  output logic              s_wren,
  output logic [KEY_W-1:0]  key_out,
  output logic              busy,
  output logic              done,
  output logic              success
);
  phase_t           state, state_nxt;
  logic             accept;
  s_ram_req_t [2:0] req;
  s_ram_req_t       s_req;

  assign accept = (state == IDLE || state == DONE) && start;

`ifdef RC4_KEY_SEARCH_EN
  logic key_max;
  assign key_max = &key_out;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start)    state_nxt = INIT;
      INIT:       if (init_fin) state_nxt = KSA;
      KSA:        if (ksa_fin)  state_nxt = PRGA;
      PRGA: if (prga_fin) begin
`ifdef RC4_KEY_SEARCH_EN
        // Exhausted key space stops in DONE rather than wrapping to zero
        state_nxt = (prga_ok || key_max) ? DONE : NEXT_KEY;
`else
        state_nxt = DONE;
`endif
      end
`ifdef RC4_KEY_SEARCH_EN
      NEXT_KEY:   state_nxt = INIT;
`endif
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      init_start <= 1'b0;
      ksa_start  <= 1'b0;
      prga_start <= 1'b0;
      key_out    <= '0;
      success    <= 1'b0;
    end else begin
      state      <= state_nxt;
      // One strobe per phase entry, aligned with the first cycle in that phase
      init_start <= (state_nxt == INIT) && (state != INIT);
      ksa_start  <= (state_nxt == KSA)  && (state != KSA);
      prga_start <= (state_nxt == PRGA) && (state != PRGA);
      if (accept) begin
        key_out <= key_in;
        success <= 1'b0;
      end
      if (state == PRGA && prga_fin) success <= prga_ok;
`ifdef RC4_KEY_SEARCH_EN
      if (state == NEXT_KEY) key_out <= key_out + KEY_W'(1);
`endif
    end
  end

  assign busy = (state == INIT) || (state == KSA) || (state == PRGA) || (state == NEXT_KEY);
  assign done = (state == DONE);

  assign req[0] = '{addr: init_addr, wdata: init_wdata, wren: init_wren};
  assign req[1] = '{addr: ksa_addr,  wdata: ksa_wdata,  wren: ksa_wren};
  assign req[2] = '{addr: prga_addr, wdata: prga_wdata, wren: prga_wren};

  rc4_ram_mux u_ram_mux (
    .phase (state),
    .req   (req),
    .s_req (s_req)
  );

  assign s_addr  = s_req.addr;
  assign s_wdata = s_req.wdata;
  assign s_wren  = s_req.wren;
endmodule
